// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Tracks the transmitter's busy over a frame, then inserts an idle gap before the next grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [7:0]                 tx_data,
  output logic                       act,
  input  logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       active,
  output logic                       err,
  input  logic                       err_clr
);
  localparam int OW   = $clog2(NUM_REQ);
  localparam int CMAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [OW-1:0] ptr, sel, idx;
  logic          found, err_set;

  // first set request strictly after the last grant, wrapping around
  always_comb begin
    sel   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = OW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (found) nxt = START;
      end
      START: begin
        // the act cycle itself counts toward the busy timeout
        cnt_nxt = CW'(1);
        nxt     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) begin
          nxt     = WAIT_DONE;
          cnt_nxt = '0;
        end else if (cnt >= CW'(BUSY_TIMEOUT - 1)) begin
          err_set = 1'b1;
          nxt     = GAP;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        cnt_nxt = '0;
        if (!busy) nxt = GAP;
      end
      GAP: begin
        if (cnt >= CW'(GAP_CYCLES - 1)) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= OW'(NUM_REQ - 1);
      owner   <= '0;
      tx_data <= '0;
      err     <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && found) begin
        tx_data <= req_data[{sel, 3'b000} +: 8];
        owner   <= sel;
        ptr     <= sel;
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  // outputs decode straight from state so reset clears them asynchronously
  assign act    = (state == START);
  assign active = (state != IDLE);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ack
    assign ack[g] = act && (owner == OW'(g));
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, timing, timeout/err, async reset.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0, rst = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [3:0] ack;
  logic [7:0] tx_data;
  logic       act, busy = 1'b0;
  logic [1:0] owner;
  logic       active, err, err_clr = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int c;

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(16), .BUSY_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .act(act), .busy(busy), .owner(owner),
    .active(active), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // call at a negedge where act is low; returns negedges waited
  task automatic wait_act(input int lim, output int cyc);
    cyc = 0;
    while (!act && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    chk("act_seen", act, 1);
  endtask

  // call at the act negedge; ends at the negedge where busy was dropped
  task automatic frame(input int dly, input int len);
    repeat (dly) @(negedge clk);
    busy = 1'b1;
    repeat (len) @(negedge clk);
    busy = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_act", act, 0);
    chk("rst_ack", ack, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_active", active, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    // single requester
    req = 4'b0100;
    req_data[23:16] = 8'h96;
    wait_act(5, c);
    chk("t1_lat", c, 1);
    chk("t1_ack", ack, 4'b0100);
    chk("t1_txd", tx_data, 8'h96);
    chk("t1_owner", owner, 2);
    chk("t1_active", active, 1);
    req = '0;
    frame(2, 10);
    chk("t1_hold", tx_data, 8'h96);

    // back-to-back: busy low sampled, 16 gap + IDLE + START
    req = 4'b0100;
    req_data[23:16] = 8'h5A;
    c = 0;
    while (!act && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 16) chk("gap_active", active, 1);
      if (c == 17) chk("idle_active", active, 0);
    end
    chk("b2b_lat", c, 18);
    chk("b2b_txd", tx_data, 8'h5A);
    req = '0;
    frame(1, 4);
    repeat (20) @(negedge clk);

    // all four held: 0,1,2,3,0 from a fresh reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 4'hF;
    req_data = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      wait_act(40, c);
      chk("rr_owner", owner, k % 4);
      chk("rr_txd", tx_data, 8'h11 * (k % 4 + 1));
      chk("rr_ack", ack, 4'b0001 << (k % 4));
      if (k < 4) begin
        frame(1, 3);
      end else begin
        // fairness: only 0 keeps requesting, 3 arrives mid-frame
        req = 4'b0001;
        @(negedge clk);
        busy = 1'b1;
        @(negedge clk);
        req = 4'b1001;
        repeat (3) @(negedge clk);
        busy = 1'b0;
      end
    end
    wait_act(40, c);
    chk("fair_owner3", owner, 3);
    chk("fair_txd3", tx_data, 8'h44);
    frame(1, 3);
    wait_act(40, c);
    chk("fair_owner0", owner, 0);
    chk("fair_txd0", tx_data, 8'h11);
    req = '0;
    frame(1, 3);
    repeat (20) @(negedge clk);

    // busy never rises: timeout 64 cycles after act
    req = 4'b0010;
    req_data = 32'h0000A500;
    wait_act(5, c);
    chk("to_owner", owner, 1);
    chk("to_txd", tx_data, 8'hA5);
    req = '0;
    repeat (63) @(negedge clk);
    chk("to_early", err, 0);
    @(negedge clk);
    chk("to_set", err, 1);
    chk("to_gap", active, 1);
    repeat (16) @(negedge clk);
    chk("to_idle", active, 0);
    chk("to_no_act", act, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", err, 0);

    // err_clr on the timeout edge: set wins
    req = 4'b0010;
    wait_act(5, c);
    req = '0;
    repeat (63) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_set_wins", err, 1);
    repeat (20) @(negedge clk);

    // reset mid-frame during WAIT_DONE
    req = 4'b0001;
    req_data = 32'h000000C3;
    wait_act(5, c);
    req = '0;
    @(negedge clk);
    busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_active", active, 1);
    chk("pre_rst_err", err, 1);
    rst = 1'b0;
    #1;
    chk("mrst_act", act, 0);
    chk("mrst_ack", ack, 0);
    chk("mrst_active", active, 0);
    chk("mrst_err", err, 0);
    chk("mrst_txd", tx_data, 0);
    busy = 1'b0;
    req = 4'b1010;
    req_data = 32'hBB00AA00;
    @(negedge clk);
    rst = 1'b1;
    wait_act(5, c);
    chk("post_rst_owner", owner, 1);
    chk("post_rst_txd", tx_data, 8'hAA);
    frame(1, 3);
    wait_act(40, c);
    chk("post_rst_owner2", owner, 3);
    chk("post_rst_txd2", tx_data, 8'hBB);
    req = '0;
    frame(1, 3);
    repeat (20) @(negedge clk);

    // busy glitch while idle does nothing
    busy = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    @(negedge clk);
    chk("glitch_active", active, 0);
    chk("glitch_act", act, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
